mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have if_req_valid/if_req_ready, input/output, 1/1, fetch request handshake.
REQ-004 SHALL have if_req_addr, input, 64, fetch byte address.
REQ-005 SHALL have if_resp_valid/if_resp_ready, output/input, 1/1, fetch response handshake.
REQ-006 SHALL have if_resp_data, output, 64, {32'b0, selected 32-bit instruction}.
REQ-007 SHALL have ls_req_valid/ls_req_ready, input/output, 1/1, load-store request handshake.
REQ-008 SHALL have ls_req_addr 64, ls_req_wen 1, ls_req_wdata 64, ls_req_wmask 64, all inputs, LSU request payload.
REQ-009 SHALL have ls_resp_valid/ls_resp_ready, output/input, 1/1, LSU response handshake.
REQ-010 SHALL have ls_resp_rdata, output, 64, load data (0 for stores).
REQ-011 SHALL have mem_en 1, mem_addr 64, mem_wen 1, mem_wdata 64, mem_wmask 64, all outputs, shared RAM port.
REQ-012 SHALL have mem_rdata, input, 64, RAM read data, valid the cycle after mem_en.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE on accepted request; ISSUE->WAIT; WAIT->RESP; RESP->IDLE when granted requester's resp_ready=1, else hold RESP.
REQ-014 SHALL drive if_req_ready/ls_req_ready high only in IDLE, at most one at a time, for the arbitration winner only (combinational from state, valids, streak).
REQ-015 SHALL arbitrate in IDLE: only one valid -> that one wins; both valid -> LSU wins unless streak==2, then fetch wins.
REQ-016 SHALL keep 2-bit streak: +1 (saturate at 2) on LSU grant while if_req_valid=1; cleared on fetch grant; unchanged otherwise.
REQ-017 SHALL register grantee, address, wen, wdata, wmask on accept edge; requester payload need not remain stable afterwards.
REQ-018 SHALL assert mem_en=1 for exactly one cycle, in ISSUE; mem_wen=1 in ISSUE only if granted LSU request has wen=1; all mem_* outputs 0 outside ISSUE.
REQ-019 SHALL drive mem_addr = (registered addr - 64'h8000_0000) & 64'hFFFF_FFFF_FFFF_FFF8, subtraction modulo 2^64 (addresses below base wrap, no error).
REQ-020 SHALL capture mem_rdata at end of WAIT into a 64-bit response register (captures 0 for stores).
REQ-021 SHALL in RESP assert resp_valid of granted requester only; fetch data = addr[2] ? rdata[63:32] : rdata[31:0], zero-extended; LSU data = full 64 bits.
REQ-022 SHALL hold resp_valid and data stable in RESP until the matching resp_ready=1; handshake completes on that edge.
REQ-023 SHALL give request-accept to resp_valid latency of exactly 3 cycles; minimum 4 cycles per transaction; no overlapping transactions.
REQ-024 SHALL ignore resp_ready of the non-granted requester and request valids outside IDLE.

Reset
REQ-025 SHALL on rst_n=0 immediately force state=IDLE, streak=0, registers=0, all ready/valid/mem_* outputs=0 regardless of clock.
REQ-026 SHALL drop any in-flight transaction on reset (no mem_en/mem_wen after reset assertion, no response after release).
REQ-027 SHALL resume arbitration on first rising edge after rst_n returns high.

Verification
REQ-028 SHALL test single fetch: if addr 0x8000_0004, mem_rdata 0x1111_2222_3333_4444 -> mem_addr 0x0, if_resp_data 0x1111_2222 three cycles after accept.
REQ-029 SHALL test store: ls addr 0x8000_0010, wen=1, wdata 0xAB, wmask 0xFF -> one cycle mem_en=mem_wen=1, mem_addr 0x10, ls_resp_rdata 0.
REQ-030 SHALL test contention: both valid continuously -> grant order LS, LS, IF, LS, LS, IF.
REQ-031 SHALL test backpressure: ls_resp_ready=0 for 5 cycles in RESP -> ls_resp_valid/data stable, no ready asserted, no mem_en.
REQ-032 SHALL test reset mid-WAIT: rst_n low -> outputs 0 same cycle; after release no stale response, next request served normally.
REQ-033 SHALL test wrap: ls addr 0x7FFF_FFFF -> mem_addr 0xFFFF_FFFF_FFFF_FFF8.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the memory arbiter: instruction-fetch request/response,
// load-store request/response and the shared single-port RAM interface.
// The slave modport is the arbiter's view; the master modport is the view
// of the requesters and the RAM combined.
interface mem_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic        if_resp_ready;
  logic [63:0] if_resp_data;

  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [63:0] ls_req_addr;
  logic        ls_req_wen;
  logic [63:0] ls_req_wdata;
  logic [63:0] ls_req_wmask;
  logic        ls_resp_valid;
  logic        ls_resp_ready;
  logic [63:0] ls_resp_rdata;

  logic        mem_en;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [63:0] mem_wmask;
  logic [63:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_resp_ready,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_resp_ready,
    input  mem_rdata,
    output if_req_ready, if_resp_valid, if_resp_data,
    output ls_req_ready, ls_resp_valid, ls_resp_rdata,
    output mem_en, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output if_req_valid, if_req_addr, if_resp_ready,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_resp_ready,
    output mem_rdata,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  ls_req_ready, ls_resp_valid, ls_resp_rdata,
    input  mem_en, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch and load-store) in front of a
// single-port RAM with one cycle of read latency. One transaction at a time:
// IDLE (arbitrate) -> ISSUE (drive RAM) -> WAIT (RAM read) -> RESP (hold
// response until the granted requester takes it). The load-store side wins
// contention except after two back-to-back wins over a waiting fetch.
module mem_arbiter (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WORD_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      r_state;
  state_e      w_nextState;
  logic [1:0]  r_streak;
  logic        r_grantLs;
  logic [63:0] r_addr;
  logic        r_wen;
  logic [63:0] r_wdata;
  logic [63:0] r_wmask;
  logic [63:0] r_rdata;

  logic        w_grantLs;
  logic        w_grantIf;
  logic        w_accept;
  logic        w_respDone;

  // Arbitration winner and handshake completion, derived from current state and inputs
  always_comb begin
    w_grantLs  = bus.ls_req_valid && (!bus.if_req_valid || (r_streak != 2'd2));
    w_grantIf  = bus.if_req_valid && !w_grantLs;
    w_accept   = (r_state == IDLE) && (w_grantLs || w_grantIf);
    w_respDone = r_grantLs ? bus.ls_resp_ready : bus.if_resp_ready;
  end

  // State register; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic: fixed three-cycle path to RESP, then wait for the taker
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    w_nextState = RESP;
      RESP:    if (w_respDone) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Capture the winner's payload on the accept edge so requesters may change it afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grantLs <= 1'b0;
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
    end else if (w_accept) begin
      r_grantLs <= w_grantLs;
      r_addr    <= w_grantLs ? bus.ls_req_addr : bus.if_req_addr;
      r_wen     <= w_grantLs && bus.ls_req_wen;
      r_wdata   <= w_grantLs ? bus.ls_req_wdata : '0;
      r_wmask   <= w_grantLs ? bus.ls_req_wmask : '0;
    end
  end

  // Streak counts LSU wins over a waiting fetch; a fetch grant clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= 2'd0;
    end else if (w_accept) begin
      if (w_grantIf)                                        r_streak <= 2'd0;
      else if (bus.if_req_valid && (r_streak != 2'd2))      r_streak <= r_streak + 2'd1;
    end
  end

  // RAM read data is valid during WAIT; stores return zero instead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_rdata <= '0;
    else if (r_state == WAIT)  r_rdata <= (r_grantLs && r_wen) ? '0 : bus.mem_rdata;
  end

  // Outputs decoded from state; readies are also held low while reset is asserted
  always_comb begin
    bus.if_req_ready  = 1'b0;
    bus.ls_req_ready  = 1'b0;
    bus.if_resp_valid = 1'b0;
    bus.if_resp_data  = '0;
    bus.ls_resp_valid = 1'b0;
    bus.ls_resp_rdata = '0;
    bus.mem_en        = 1'b0;
    bus.mem_wen       = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.mem_wmask     = '0;
    case (r_state)
      IDLE: begin
        bus.if_req_ready = rst_n && w_grantIf;
        bus.ls_req_ready = rst_n && w_grantLs;
      end
      ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wen   = r_grantLs && r_wen;
        bus.mem_addr  = (r_addr - BASE_ADDR) & WORD_MASK;
        bus.mem_wdata = r_wdata;
        bus.mem_wmask = r_wmask;
      end
      RESP: begin
        if (r_grantLs) begin
          bus.ls_resp_valid = 1'b1;
          bus.ls_resp_rdata = r_rdata;
        end else begin
          bus.if_resp_valid = 1'b1;
          bus.if_resp_data  = {32'b0, (r_addr[2] ? r_rdata[63:32] : r_rdata[31:0])};
        end
      end
      default: ;
    endcase
  end

endmodule
